data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_pkg.sv | 30 +++
 rtl/rr_arbiter2.sv | 86 ++++++++
 rtl/data_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter_pkg
// Description : Shared types and helpers for the two-port data memory arbiter:
//               FSM state encoding, port index constants and the word
//               alignment / range check.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int c_PORT_PIPE   = 0;   // pipeline MEM stage
    localparam int c_PORT_LOADER = 1;   // loader / debug port
    localparam int c_WORD_BITS   = 64;

    // A request is serviceable only when it names a whole 8-byte word that
    // lies entirely inside the attached memory.
    function automatic logic addr_ok(input logic [63:0] byte_addr,
                                     input int unsigned mem_bytes);
        logic [63:0] w_limit;
        w_limit = 64'(mem_bytes) - 64'd8;
        return (byte_addr[2:0] == 3'b000) && (byte_addr <= w_limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter with a bounded lock override.
//               A port granted with lock high becomes owner and keeps
//               exclusive grants until it drops lock/req or LOCK_MAX grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 #(
    parameter int LOCK_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       grant_en,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt,
    output logic       gnt_port
);

    localparam int c_CNT_W = $clog2(LOCK_MAX + 1);

    logic               r_last;         // port granted most recently
    logic               r_owner_valid;
    logic               r_owner;
    logic [c_CNT_W-1:0] r_lock_cnt;

    logic               w_owner_active;
    logic               w_pick;
    logic               w_any;
    logic [c_CNT_W-1:0] w_next_cnt;

    // Pick a winner: an active lock owner first, otherwise round-robin on a tie.
    always_comb begin
        w_owner_active = r_owner_valid && req[r_owner] && lock[r_owner];
        w_any          = |req;
        if (w_owner_active) begin
            w_pick = r_owner;
        end else if (&req) begin
            w_pick = ~r_last;
        end else begin
            w_pick = req[1];
        end
        w_next_cnt = w_owner_active ? (r_lock_cnt + 1'b1) : c_CNT_W'(1);
        gnt        = 2'b00;
        if (grant_en && w_any) begin
            gnt = w_pick ? 2'b10 : 2'b01;
        end
    end

    assign gnt_port = w_pick;

    // Track round-robin history, lock ownership and the locked-grant budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last        <= 1'b1;          // makes port 0 win the first tie
            r_owner_valid <= 1'b0;
            r_owner       <= 1'b0;
            r_lock_cnt    <= '0;
        end else if (grant_en) begin
            if (w_any) begin
                r_last <= w_pick;
                if (lock[w_pick]) begin
                    if (w_next_cnt >= c_CNT_W'(LOCK_MAX)) begin
                        // Budget exhausted: force release so the other port
                        // gets the next tie.
                        r_owner_valid <= 1'b0;
                        r_lock_cnt    <= '0;
                    end else begin
                        r_owner_valid <= 1'b1;
                        r_owner       <= w_pick;
                        r_lock_cnt    <= w_next_cnt;
                    end
                end else begin
                    r_owner_valid <= 1'b0;
                    r_lock_cnt    <= '0;
                end
            end else if (r_owner_valid && !req[r_owner]) begin
                r_owner_valid <= 1'b0;
                r_lock_cnt    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Arbitrates a pipeline port and a loader/debug port onto one
//               64-bit data memory. Grant at T, memory access at T+1,
//               ack (with err/rdata) at T+2.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int LOCK_MAX  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [1:0]   we,
    input  logic [1:0]   lock,
    input  logic [127:0] addr,
    input  logic [127:0] wdata,
    output logic [1:0]   gnt,
    output logic [1:0]   ack,
    output logic         err,
    output logic [63:0]  rdata,
    output logic [63:0]  mem_addr,
    output logic [63:0]  mem_wdata,
    output logic         mem_we,
    output logic         mem_re,
    input  logic [63:0]  mem_rdata
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_port;
    logic                   r_we;
    logic                   r_bad;
    logic [c_WORD_BITS-1:0] r_addr;
    logic [c_WORD_BITS-1:0] r_wdata;
    logic [c_WORD_BITS-1:0] r_rdata;
    logic [1:0]             r_ack;
    logic                   r_err;

    logic                   w_grant_en;
    logic [1:0]             w_arb_gnt;
    logic                   w_arb_port;
    logic [c_WORD_BITS-1:0] w_sel_addr;
    logic [c_WORD_BITS-1:0] w_sel_wdata;
    logic                   w_sel_we;
    logic                   w_mem_re;
    logic                   w_mem_we;

    assign w_grant_en = (r_state == ST_IDLE) && !reset;

    rr_arbiter2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .grant_en (w_grant_en),
        .req      (req),
        .lock     (lock),
        .gnt      (w_arb_gnt),
        .gnt_port (w_arb_port)
    );

    assign w_sel_addr  = w_arb_port ? addr[64*c_PORT_LOADER +: 64]  : addr[64*c_PORT_PIPE +: 64];
    assign w_sel_wdata = w_arb_port ? wdata[64*c_PORT_LOADER +: 64] : wdata[64*c_PORT_PIPE +: 64];
    assign w_sel_we    = w_arb_port ? we[c_PORT_LOADER] : we[c_PORT_PIPE];

    // State register; async reset drops ACCESS (and thus the strobes) at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: accept in IDLE, spend exactly one cycle in ACCESS.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (|req) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Memory strobes: only in ACCESS and only for a serviceable address.
    always_comb begin
        w_mem_re = 1'b0;
        w_mem_we = 1'b0;
        if (r_state == ST_ACCESS && !r_bad) begin
            w_mem_re = !r_we;
            w_mem_we = r_we;
        end
    end

    // Capture the granted request, then the access result for the ack cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_bad   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 2'b00;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 2'b00;
            r_err <= 1'b0;
            if (|w_arb_gnt) begin
                r_port  <= w_arb_port;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_bad   <= !addr_ok(w_sel_addr, MEM_BYTES);
            end
            if (r_state == ST_ACCESS) begin
                r_ack   <= r_port ? 2'b10 : 2'b01;
                r_err   <= r_bad;
                r_rdata <= w_mem_re ? mem_rdata : '0;
            end
        end
    end

    assign gnt       = reset ? 2'b00 : w_arb_gnt;
    assign ack       = r_ack;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = w_mem_we;
    assign mem_re    = w_mem_re;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Self-checking bench for data_mem_arbiter with an attached
//               word memory and a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int MEM_BYTES = 256;
    localparam int LOCK_MAX  = 8;
    localparam int AW        = $clog2(MEM_BYTES);
    localparam int WORDS     = MEM_BYTES / 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req, we, lock;
    logic [127:0] addr, wdata;
    logic [1:0]   gnt, ack;
    logic         err;
    logic [63:0]  rdata, mem_addr, mem_wdata, mem_rdata;
    logic         mem_we, mem_re;

    logic [63:0]  mem     [WORDS];
    logic [63:0]  ref_mem [WORDS];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;

    data_mem_arbiter #(.MEM_BYTES(MEM_BYTES), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
        .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .err(err),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached memory: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr[AW-1:3]];
    always @(posedge clk) if (mem_we) mem[mem_addr[AW-1:3]] <= mem_wdata;

    function automatic bit model_ok(input logic [63:0] a);
        return (a % 8 == 0) && (a <= MEM_BYTES - 8);
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; req = 2'b00; lock = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drives one request on port p and records what the DUT did; no checking.
    task automatic do_txn(input int p, input logic w, input logic [63:0] a,
                          input logic [63:0] d, output int g_cyc, output int s_cyc,
                          output int a_cyc, output logic [63:0] rd,
                          output logic e, output logic [1:0] ack_v);
        g_cyc = -1; s_cyc = -1; a_cyc = -1; rd = '0; e = 1'b0; ack_v = 2'b00;
        @(posedge clk); #1;
        req[p] = 1'b1; we[p] = w; addr[64*p +: 64] = a; wdata[64*p +: 64] = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt[p]) begin g_cyc = cyc; break; end
        end
        @(posedge clk); #1;
        req[p] = 1'b0;
        addr[64*p +: 64]  = {$urandom, $urandom};
        wdata[64*p +: 64] = {$urandom, $urandom};
        if (g_cyc >= 0) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if ((mem_re || mem_we) && s_cyc < 0) s_cyc = cyc;
                if (|ack) begin
                    a_cyc = cyc; rd = rdata; e = err; ack_v = ack;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b11; we = 2'b01; lock = 2'b00;
        addr = {64'h8, 64'h10}; wdata = '1;
        @(negedge clk);
        checks++;
        if ({gnt, ack, err, mem_we, mem_re} !== 7'd0 || rdata !== 64'd0 ||
            mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b ack=%b err=%b we=%b re=%b rdata=%h maddr=%h mwdata=%h, required all zero",
                     gnt, ack, err, mem_we, mem_re, rdata, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        req = 2'b00;
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        int g, s, a; logic [63:0] rd; logic e; logic [1:0] av;
        do_txn(0, 1'b1, 64'h10, 64'h1122334455667788, g, s, a, rd, e, av);
        ref_mem[2] = 64'h1122334455667788;
        checks++;
        if (g < 0 || s != g + 1 || a != g + 2 || av !== 2'b01 || e !== 1'b0 || rd !== 64'd0) begin
            failures++;
            $display("FAIL store_timing: gnt=%0d strobe=%0d ack=%0d ackv=%b err=%b rdata=%h, required strobe=gnt+1 ack=gnt+2 ackv=01 err=0 rdata=0",
                     g, s, a, av, e, rd);
        end
        do_txn(0, 1'b0, 64'h10, 64'h0, g, s, a, rd, e, av);
        checks++;
        if (g < 0 || a != g + 2 || av !== 2'b01 || e !== 1'b0 || rd !== ref_mem[2]) begin
            failures++;
            $display("FAIL load_after_store: gnt=%0d ack=%0d ackv=%b err=%b rdata=%h, required ack=gnt+2 ackv=01 err=0 rdata=%h",
                     g, a, av, e, rd, ref_mem[2]);
        end
    endtask

    task automatic test_alternate();
        int gp[$]; int gc[$];
        apply_reset();
        we = 2'b00; addr = {64'h28, 64'h20}; req = 2'b11;
        for (int i = 0; i < 40 && gp.size() < 8; i++) begin
            @(negedge clk);
            if (gnt == 2'b11) begin
                checks++; failures++;
                $display("FAIL alt_onehot: gnt=%b, required one-hot", gnt);
            end else if (gnt == 2'b01) begin gp.push_back(0); gc.push_back(cyc); end
            else if (gnt == 2'b10) begin gp.push_back(1); gc.push_back(cyc); end
        end
        @(posedge clk); #1; req = 2'b00;
        repeat (4) @(posedge clk);
        checks++;
        if (gp.size() != 8) begin
            failures++;
            $display("FAIL alt_count: grants=%0d, required 8", gp.size());
        end
        for (int i = 0; i < gp.size(); i++) begin
            checks++;
            if (gp[i] != i % 2 || (i > 0 && gc[i] - gc[i-1] != 2)) begin
                failures++;
                $display("FAIL alt_grant%0d: port=%0d spacing=%0d, required port=%0d spacing=2",
                         i, gp[i], (i > 0) ? gc[i] - gc[i-1] : 2, i % 2);
            end
        end
    endtask

    task automatic test_errors();
        logic [63:0] tbl [4];
        int g, s, a; logic [63:0] rd; logic e; logic [1:0] av; bit ok;
        tbl[0] = 64'h0C; tbl[1] = 64'hF9; tbl[2] = 64'hF8; tbl[3] = 64'h100;
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1'b0, tbl[i], 64'h0, g, s, a, rd, e, av);
            ok = model_ok(tbl[i]);
            checks++;
            if (g < 0 || a != g + 2 || av !== 2'b10 || e !== !ok ||
                rd !== (ok ? ref_mem[tbl[i] / 8] : 64'd0) || (!ok && s != -1)) begin
                failures++;
                $display("FAIL err_addr_%h: ack=%0d(gnt %0d) ackv=%b err=%b rdata=%h strobe=%0d, required ack=gnt+2 ackv=10 err=%b rdata=%h strobe=%0d",
                         tbl[i], a, g, av, e, rd, s, !ok,
                         ok ? ref_mem[tbl[i] / 8] : 64'd0, ok ? s : -1);
            end
        end
    endtask

    task automatic test_lock();
        int gp[$];
        apply_reset();
        we = 2'b00; addr = {64'h38, 64'h30}; lock = 2'b01; req = 2'b11;
        for (int i = 0; i < 60 && gp.size() < LOCK_MAX + 1; i++) begin
            @(negedge clk);
            if (gnt[0]) gp.push_back(0);
            else if (gnt[1]) gp.push_back(1);
        end
        @(posedge clk); #1; req = 2'b00; lock = 2'b00;
        repeat (4) @(posedge clk);
        checks++;
        if (gp.size() != LOCK_MAX + 1) begin
            failures++;
            $display("FAIL lock_count: grants=%0d, required %0d", gp.size(), LOCK_MAX + 1);
        end
        for (int i = 0; i < gp.size(); i++) begin
            checks++;
            if (gp[i] != ((i < LOCK_MAX) ? 0 : 1)) begin
                failures++;
                $display("FAIL lock_grant%0d: port=%0d, required %0d", i, gp[i], (i < LOCK_MAX) ? 0 : 1);
            end
        end
    endtask

    task automatic test_reset_during_access();
        int g, s, a; logic [63:0] rd; logic e; logic [1:0] av; int acks; int gcyc; logic [1:0] first;
        do_txn(0, 1'b1, 64'h40, 64'hAAAA_BBBB_CCCC_DDDD, g, s, a, rd, e, av);
        ref_mem[8] = 64'hAAAA_BBBB_CCCC_DDDD;
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[63:0] = 64'h40; wdata[63:0] = 64'h5555_6666_7777_8888;
        gcyc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt[0]) begin gcyc = cyc; break; end
        end
        @(posedge clk); #1;
        req = 2'b00;
        reset = 1'b1;
        #1;
        checks++;
        if (gcyc < 0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
            failures++;
            $display("FAIL rst_access_strobe: gnt_cyc=%0d mem_we=%b mem_re=%b, required grant seen and strobes 0", gcyc, mem_we, mem_re);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (|ack) acks++;
        end
        checks++;
        if (acks != 0 || mem[8] !== ref_mem[8]) begin
            failures++;
            $display("FAIL rst_access_effect: acks=%0d mem=%h, required acks=0 mem=%h", acks, mem[8], ref_mem[8]);
        end
        @(posedge clk); #1;
        we = 2'b00; addr = {64'h8, 64'h0}; req = 2'b11;
        first = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (|gnt) begin first = gnt; break; end
        end
        @(posedge clk); #1; req = 2'b00;
        repeat (4) @(posedge clk);
        checks++;
        if (first !== 2'b01) begin
            failures++;
            $display("FAIL rst_tie_port0: gnt=%b, required 01", first);
        end
    endtask

    task automatic test_random();
        int g, s, a, p; logic [63:0] rd, ad, dd, exp_rd; logic e, w; logic [1:0] av; bit ok;
        for (int n = 0; n < 40; n++) begin
            p  = $urandom_range(0, 1);
            w  = 1'($urandom_range(0, 1));
            ad = ($urandom_range(0, 4) != 0) ? 64'($urandom_range(0, WORDS - 1) * 8)
                                             : 64'($urandom_range(0, MEM_BYTES + 16));
            dd = {$urandom, $urandom};
            ok = model_ok(ad);
            exp_rd = (!w && ok) ? ref_mem[ad / 8] : 64'd0;
            do_txn(p, w, ad, dd, g, s, a, rd, e, av);
            if (w && ok) ref_mem[ad / 8] = dd;
            checks++;
            if (g < 0 || a != g + 2 || av !== (p == 1 ? 2'b10 : 2'b01) || e !== !ok || rd !== exp_rd) begin
                failures++;
                $display("FAIL rand%0d port%0d we=%b addr=%h: ack=%0d(gnt %0d) ackv=%b err=%b rdata=%h, required ack=gnt+2 err=%b rdata=%h",
                         n, p, w, ad, a, g, av, e, rd, !ok, exp_rd);
            end
        end
        checks++;
        for (int i = 0; i < WORDS; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                failures++;
                $display("FAIL rand_mem_word%0d: got %h, required %h", i, mem[i], ref_mem[i]);
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; we = 2'b00; lock = 2'b00; addr = '0; wdata = '0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_store_load();
        test_alternate();
        test_errors();
        test_lock();
        test_reset_during_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
